// File: rtl/siphash_msg_sequencer.sv
// rtl/siphash_msg_sequencer.sv - byte-stream packer, length padder and command sequencer for a SipHash core
module siphash_msg_sequencer #(
  parameter logic [3:0] COMP_ROUNDS  = 4'd2,
  parameter logic [3:0] FINAL_ROUNDS = 4'd4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         start_empty,
  input  logic [127:0] key,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  output logic [127:0] core_key,
  output logic [63:0]  core_mi,
  input  logic         core_ready,
  input  logic [63:0]  core_word,
  input  logic         core_word_valid,
  output logic [63:0]  digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_COLLECT, S_PAD, S_COMP_ISSUE,
    S_COMP_WAIT, S_FIN_ISSUE, S_FIN_WAIT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    word_q, word_d;
  logic [7:0]     len_q, len_d;
  logic           last_q, last_d;
  logic           pad_done_q, pad_done_d;
  logic [127:0]   key_q, key_d;
  logic [63:0]    digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;
  logic           init_q, init_d;
  logic           comp_q, comp_d;
  logic           fin_q, fin_d;

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    len_d          = len_q;
    last_d         = last_q;
    pad_done_d     = pad_done_q;
    key_d          = key_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          key_d          = key;
          len_d          = 8'd0;
          word_d         = 64'd0;
          last_d         = start_empty;
          pad_done_d     = 1'b0;
          digest_valid_d = 1'b0;
          state_d        = S_INIT;
        end
      end
      S_INIT: state_d = last_q ? S_PAD : S_COLLECT;
      S_COLLECT: begin
        if (in_valid) begin
          for (int b = 0; b < 8; b++) begin
            if (len_q[2:0] == 3'(b)) word_d[8*b +: 8] = in_data;
          end
          len_d  = len_q + 8'd1;
          last_d = in_last;
          if (len_q[2:0] == 3'd7) state_d = S_COMP_ISSUE;
          else if (in_last)       state_d = S_PAD;
        end
      end
      S_PAD: begin
        // Unwritten upper bytes are still zero from the previous clear.
        word_d[63:56] = len_q;
        pad_done_d    = 1'b1;
        state_d       = S_COMP_ISSUE;
      end
      S_COMP_ISSUE: state_d = S_COMP_WAIT;
      S_COMP_WAIT: begin
        if (core_ready) begin
          word_d = 64'd0;
          if (pad_done_q)  state_d = S_FIN_ISSUE;
          else if (last_q) state_d = S_PAD;
          else             state_d = S_COLLECT;
        end
      end
      S_FIN_ISSUE: state_d = S_FIN_WAIT;
      S_FIN_WAIT: begin
        if (core_word_valid) begin
          digest_d       = core_word;
          digest_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are flopped decodes of the next state so they align with it.
    init_d = (state_d == S_INIT);
    comp_d = (state_d == S_COMP_ISSUE);
    fin_d  = (state_d == S_FIN_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      word_q         <= 64'd0;
      len_q          <= 8'd0;
      last_q         <= 1'b0;
      pad_done_q     <= 1'b0;
      key_q          <= 128'd0;
      digest_q       <= 64'd0;
      digest_valid_q <= 1'b0;
      init_q         <= 1'b0;
      comp_q         <= 1'b0;
      fin_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      len_q          <= len_d;
      last_q         <= last_d;
      pad_done_q     <= pad_done_d;
      key_q          <= key_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      init_q         <= init_d;
      comp_q         <= comp_d;
      fin_q          <= fin_d;
    end
  end

  assign in_ready                = (state_q == S_COLLECT);
  assign busy                    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign core_initalize          = init_q;
  assign core_compress           = comp_q;
  assign core_finalize           = fin_q;
  assign core_long               = 1'b0;
  assign core_compression_rounds = COMP_ROUNDS;
  assign core_final_rounds       = FINAL_ROUNDS;
  assign core_key                = key_q;
  assign core_mi                 = word_q;
  assign digest                  = digest_q;
  assign digest_valid            = digest_valid_q;

endmodule

// File: tb/tb_siphash_msg_sequencer.sv
// tb/tb_siphash_msg_sequencer.sv - vector bench for the SipHash message sequencer with a behavioural core
module tb_siphash_msg_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, start_empty = 1'b0;
  logic [127:0] key = 128'd0;
  logic         in_valid = 1'b0, in_last = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic [3:0]   core_compression_rounds, core_final_rounds;
  logic [127:0] core_key;
  logic [63:0]  core_mi;
  logic         core_ready;
  logic [63:0]  core_word;
  logic         core_word_valid;
  logic [63:0]  digest;
  logic         digest_valid, busy;

  localparam logic [127:0] KEY_STD = 128'h0f0e0d0c0b0a09080706050403020100;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  siphash_msg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_empty(start_empty), .key(key),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .core_initalize(core_initalize), .core_compress(core_compress), .core_finalize(core_finalize),
    .core_long(core_long), .core_compression_rounds(core_compression_rounds),
    .core_final_rounds(core_final_rounds), .core_key(core_key), .core_mi(core_mi),
    .core_ready(core_ready), .core_word(core_word), .core_word_valid(core_word_valid),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int n);
    logic [63:0] a, b, c, d;
    {a, b, c, d} = s;
    for (int i = 0; i < n; i++) begin
      a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
      c = c + d; d = rotl(d, 16); d = d ^ c;
      a = a + d; d = rotl(d, 21); d = d ^ a;
      c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m, input int n);
    logic [255:0] t;
    t = sip_rounds({s[255:64], s[63:0] ^ m}, n);
    return {t[255:192] ^ m, t[191:0]};
  endfunction

  function automatic logic [63:0] sip_fin(input logic [255:0] s, input int n);
    logic [255:0] t;
    t = sip_rounds({s[255:128], s[127:64] ^ 64'hff, s[63:0]}, n);
    return t[255:192] ^ t[191:128] ^ t[127:64] ^ t[63:0];
  endfunction

  // Behavioural core: ready drops on each command and returns after one cycle per round.
  logic [255:0] vs;
  int           cnt;
  logic         fin_pend;
  int           n_init = 0, n_comp = 0, n_fin = 0;
  logic [63:0]  mi_log[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready      <= 1'b1;
      core_word_valid <= 1'b0;
      core_word       <= 64'd0;
      cnt             <= 0;
      fin_pend        <= 1'b0;
      vs              <= 256'd0;
    end else begin
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          core_ready <= 1'b1;
          if (fin_pend) core_word_valid <= 1'b1;
        end
      end
      if (core_initalize) begin
        n_init          <= n_init + 1;
        core_word_valid <= 1'b0;
        vs <= {core_key[63:0] ^ 64'h736f6d6570736575, core_key[127:64] ^ 64'h646f72616e646f6d,
               core_key[63:0] ^ 64'h6c7967656e657261, core_key[127:64] ^ 64'h7465646279746573};
      end
      if (core_compress) begin
        n_comp <= n_comp + 1;
        mi_log.push_back(core_mi);
        vs              <= sip_comp(vs, core_mi, int'(core_compression_rounds));
        core_ready      <= 1'b0;
        core_word_valid <= 1'b0;
        cnt             <= int'(core_compression_rounds);
        fin_pend        <= 1'b0;
      end
      if (core_finalize) begin
        n_fin           <= n_fin + 1;
        core_word       <= sip_fin(vs, int'(core_final_rounds));
        core_ready      <= 1'b0;
        core_word_valid <= 1'b0;
        cnt             <= int'(core_final_rounds);
        fin_pend        <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          empty;
    int          nbytes;
    bit          hold;
    bit          mid_start;
    int          ncomp;
    logic [63:0] mi0;
    logic [63:0] mi1;
    bit          chk_dig;
    logic [63:0] dig;
  } vec_t;

  task automatic do_start(input bit e, input logic [127:0] k);
    @(posedge clk); #1;
    start = 1'b1; start_empty = e; key = k;
    @(posedge clk); #1;
    start = 1'b0; start_empty = 1'b0;
    @(negedge clk);
    chk("dv_cleared_after_start", {63'd0, digest_valid}, 64'd0);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("core_key_latched", core_key[63:0] ^ core_key[127:64], k[63:0] ^ k[127:64]);
  endtask

  task automatic run_vec(input vec_t v);
    int c0, i0, f0, cyc, stall_hi, stall_lo;
    bit timeout;
    mi_log.delete();
    c0 = n_comp; i0 = n_init; f0 = n_fin;
    stall_hi = 0; stall_lo = 0; timeout = 0;
    do_start(v.empty, KEY_STD);
    for (int i = 0; i < v.nbytes && !timeout; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = (i == v.nbytes - 1);
      cyc = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        if (i >= 8) stall_hi++;
        else if (i >= 1) stall_lo++;
        if (++cyc > 200) begin timeout = 1; break; end
      end
      @(posedge clk); #1;
      if (!v.hold) begin
        in_valid = 1'b0;
        if (v.mid_start && i == 2) begin start = 1'b1; start_empty = 1'b1; key = ~KEY_STD; end
        @(posedge clk); #1;
        start = 1'b0; start_empty = 1'b0;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("byte_accept_timeout", {63'd0, timeout}, 64'd0);
    cyc = 0;
    while (!digest_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("digest_valid_seen", {63'd0, digest_valid}, 64'd1);
    if (v.empty) chk("empty_latency_le16", {63'd0, cyc <= 16}, 64'd1);
    chk("compress_count", 64'(n_comp - c0), 64'(v.ncomp));
    chk("init_count", 64'(n_init - i0), 64'd1);
    chk("finalize_count", 64'(n_fin - f0), 64'd1);
    if (mi_log.size() > 0) chk("mi_word0", mi_log[0], v.mi0);
    if (v.ncomp > 1 && mi_log.size() > 1) chk("mi_word1", mi_log[1], v.mi1);
    if (v.chk_dig) chk("digest", digest, v.dig);
    chk("busy_done", {63'd0, busy}, 64'd0);
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    if (v.hold && v.nbytes > 8) chk("stall_after_word", {63'd0, stall_hi > 0}, 64'd1);
    if (v.hold && v.nbytes > 1) chk("no_stall_in_word", 64'(stall_lo), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1, 0,  1, 0, 1, 64'h0, 64'h0, 1, 64'h726fdb47dd0e0e31};
    vecs[1] = '{0, 8,  1, 0, 2, 64'h0706050403020100, 64'h0800000000000000, 1, 64'h93f5f5799a932462};
    vecs[2] = '{0, 15, 1, 0, 2, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 1, 64'ha129ca6149be45e5};
    vecs[3] = '{0, 3,  0, 0, 1, 64'h0300000000020100, 64'h0, 0, 64'h0};
    vecs[4] = '{0, 15, 0, 1, 2, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 1, 64'ha129ca6149be45e5};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_outputs", {busy, in_ready, digest_valid, core_initalize, core_compress, core_finalize, core_long},
          64'd0);
      chk("rst_digest", digest, 64'd0);
    end
    chk("rst_core_mi", core_mi, 64'd0);
    chk("rst_core_key", core_key[63:0] | core_key[127:64], 64'd0);
    chk("rounds", {core_compression_rounds, core_final_rounds}, 64'h24);
    chk("rst_no_strobes", 64'(n_init + n_comp + n_fin), 64'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Reset while the core is still working on the padding word.
    begin
      int cyc;
      do_start(1'b1, KEY_STD);
      cyc = 0;
      while (!core_compress && cyc < 50) begin @(negedge clk); cyc++; end
      chk("reach_comp_issue", {63'd0, core_compress}, 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_mid_dv", {63'd0, digest_valid}, 64'd0);
      chk("rst_mid_digest", digest, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_vec(vecs[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/siphash_msg_sequencer.md
Name: siphash_msg_sequencer

Overview:
Byte-stream front end and sequencer for the SipHash core. It packs an arbitrary-length byte message into 64-bit little-endian words and applies SipHash length padding. It drives the core's initalize/compress/finalize strobes in order, waiting on core ready between commands, and then captures and presents the 64-bit digest. It sits between a byte-oriented host interface and the core's wide interface.

Parameters:
COMP_ROUNDS, 4'd2, value driven on core_compression_rounds (c of SipHash-c-d)
FINAL_ROUNDS, 4'd4, value driven on core_final_rounds (d)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin new message; honoured only in IDLE or DONE
start_empty  in  1  sampled with start; 1 = zero-length message (no bytes follow)
key  in  128  sampled with start; {k1, k0}, k0 in [63:0]
in_valid  in  1  byte valid
in_data  in  8  message byte, first byte = least significant byte of word
in_last  in  1  marks final byte of message
in_ready  out  1  byte accepted when in_valid && in_ready
core_initalize  out  1  strobe to core
core_compress  out  1  strobe to core
core_finalize  out  1  strobe to core
core_long  out  1  constant 0
core_compression_rounds  out  4  = COMP_ROUNDS
core_final_rounds  out  4  = FINAL_ROUNDS
core_key  out  128  latched key
core_mi  out  64  packed word register
core_ready  in  1  core ready
core_word  in  64  core siphash_word[63:0]
core_word_valid  in  1  core siphash_word_valid
digest  out  64  captured result
digest_valid  out  1  high from capture until next accepted start
busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset values: all strobes 0, in_ready 0, digest 0, digest_valid 0, busy 0, word_reg 0, len_reg 0, key_reg 0, state IDLE.
- Registers:
  - word_reg[63:0]
  - len_reg[7:0]: total length mod 256; wraps 255->0 silently. len_reg[2:0] is the byte index within the word.
  - last_reg: last byte seen.
  - pad_done: padding word sent.
- All strobes are registered decodes of state and are high for exactly one cycle.
- States:
  - IDLE/DONE:
    - On start, latch key and clear len_reg, word_reg, last_reg, pad_done, digest_valid. Go to INIT.
    - If start_empty, also set last_reg=1.
  - INIT:
    - core_initalize=1 for one cycle.
    - Go to PAD if last_reg, else to COLLECT. The core completes init in one cycle with ready held high.
  - COLLECT:
    - in_ready=1.
    - On accept: word_reg[8*len_reg[2:0] +: 8] <= in_data; len_reg++; last_reg <= in_last.
    - If the byte index was 7, go to COMP_ISSUE. Otherwise, if in_last, go to PAD. Otherwise stay.
  - PAD:
    - word_reg[63:56] <= len_reg; bytes above the index are already 0; set pad_done.
    - Go to COMP_ISSUE.
  - COMP_ISSUE:
    - core_compress=1; core_mi=word_reg.
    - Go to COMP_WAIT.
  - COMP_WAIT:
    - Wait for core_ready==1. Core ready is already 0 in the cycle after the strobe, so no extra guard cycle is needed.
    - On ready, clear word_reg, then:
      - if pad_done, go to FIN_ISSUE;
      - else if last_reg (message ended on a word boundary), go to PAD;
      - else go to COLLECT.
  - FIN_ISSUE:
    - core_finalize=1.
    - Go to FIN_WAIT.
  - FIN_WAIT:
    - When core_word_valid==1: digest <= core_word; digest_valid <= 1.
    - Go to DONE.
- Word-boundary messages (len mod 8 == 0, including empty) get an extra pad word whose only nonzero byte is [63:56]=len.
- in_ready is 0 in every state except COLLECT; in_valid is ignored there.
- start outside IDLE/DONE is ignored; the message in progress continues unaffected.
- A start and in_last cannot collide, because in_ready=0 in IDLE/DONE.
- Reset mid-operation: all state returns to reset values immediately. The core shares the same reset, so no recovery sequence is needed.
- Latency, empty message, c=2/d=4, core_ready seen 1 cycle after its register update:
  - start -> INIT -> PAD -> COMP_ISSUE -> COMP_WAIT (~4 cycles) -> FIN_ISSUE -> FIN_WAIT (~6 cycles) -> DONE.
  - digest_valid rises at most 16 cycles after start.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, in_ready 0, busy 0; core strobes never asserted.
- key=0x0f0e0d0c0b0a09080706050403020100, start with start_empty=1 -> exactly one compress with core_mi=0x0000000000000000, then finalize; digest=0x726fdb47dd0e0e31.
- Same key, 8 bytes 00..07 with in_last on 07 -> two compresses:
  - core_mi=0x0706050403020100;
  - then 0x0800000000000000;
  - digest=0x93f5f5799a932462.
- Same key, 15 bytes 00..0e, in_valid held high -> in_ready drops after byte 07 until core_ready returns; second core_mi=0x0f0e0d0c0b0a0908; digest=0xa129ca6149be45e5.
- start pulsed mid-collection -> ignored; digest for the original message unchanged. A second start in DONE clears digest_valid the next cycle and runs the new message correctly.
- reset_n asserted during COMP_WAIT -> busy, in_ready, digest_valid all 0 immediately. After release, the empty-message run yields 0x726fdb47dd0e0e31.
